// File: rtl/blob_pattern_gen.sv
// ---------------------------------------------------------------------------
// blob_pattern_gen
//
// Synthetic marker-scene source. Produces a VGA-style raster (HS, VS, pixel
// counters) and a binary pixel flag that is high inside up to four blobs
// centred on programmable coordinates. The signal set matches what the point
// finder consumes, so the finder can be driven without a camera.
//
// Blob coordinates are double-buffered: i_LOAD captures a new set into a
// staging copy, and the staging copy moves into the active (shadow) copy only
// on the last pixel of a frame. The new set therefore applies from pixel (0,0)
// of the next frame.
//
// Build option:
//   BLOB_DIAMOND_EN  defined   -> diamond blobs, |dH|+|dV| <= RADIUS
//                    undefined -> square blobs, |dH|<=RADIUS and |dV|<=RADIUS
//
// Ports:
//   CLK              pixel clock
//   RESET_N          asynchronous active-low reset
//   i_ENABLE         gates BINARY_FLAG (raster always runs)
//   i_LOAD           single-cycle strobe: stage i_POINT_EN / i_POINT_H/V_*
//   i_POINT_EN[3:0]  per-blob enable
//   i_POINT_H_0..3   blob centre columns
//   i_POINT_V_0..3   blob centre lines
//   VGA_HS, VGA_VS   active-low syncs
//   H_CNT, V_CNT     current pixel position
//   BINARY_FLAG      current pixel lies inside an enabled blob
//   o_LOAD_PENDING   a staged set is waiting for the frame boundary
//   o_LOAD_DONE      one-cycle pulse on pixel (0,0) when a set was applied
//   o_FRAME_CNT      frames completed (wraps)
//
// Every output is a register. The counters, syncs and flag are all computed
// from the *next* pixel position and registered together, so in any cycle they
// describe the same pixel.
// ---------------------------------------------------------------------------
module blob_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RADIUS   = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        i_ENABLE,
  input  logic        i_LOAD,
  input  logic [3:0]  i_POINT_EN,
  input  logic [15:0] i_POINT_H_0,
  input  logic [15:0] i_POINT_H_1,
  input  logic [15:0] i_POINT_H_2,
  input  logic [15:0] i_POINT_H_3,
  input  logic [15:0] i_POINT_V_0,
  input  logic [15:0] i_POINT_V_1,
  input  logic [15:0] i_POINT_V_2,
  input  logic [15:0] i_POINT_V_3,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [15:0] H_CNT,
  output logic [15:0] V_CNT,
  output logic        BINARY_FLAG,
  output logic        o_LOAD_PENDING,
  output logic        o_LOAD_DONE,
  output logic [15:0] o_FRAME_CNT
);

  // -------------------------------------------------------------------------
  // Raster geometry
  // -------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT_W    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT_W    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_FIRST   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_LAST    = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_FIRST   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_LAST    = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

  // -------------------------------------------------------------------------
  // Blob hit test. Differences are taken as 17-bit signed values so a centre
  // near the edge never wraps around to the far side of the raster.
  // -------------------------------------------------------------------------
  function automatic logic blob_hit(input logic [15:0] h, input logic [15:0] v,
                                    input logic [15:0] ch, input logic [15:0] cv);
    logic signed [16:0] dh;
    logic signed [16:0] dv;
    logic [16:0]        ah;
    logic [16:0]        av;
`ifdef BLOB_DIAMOND_EN
    logic [17:0]        dist;
`endif
    dh = $signed({1'b0, h}) - $signed({1'b0, ch});
    dv = $signed({1'b0, v}) - $signed({1'b0, cv});
    ah = dh[16] ? 17'(-dh) : 17'(dh);
    av = dv[16] ? 17'(-dv) : 17'(dv);
`ifdef BLOB_DIAMOND_EN
    dist = {1'b0, ah} + {1'b0, av};
    return dist <= 18'(RADIUS);
`else
    return (ah <= 17'(RADIUS)) && (av <= 17'(RADIUS));
`endif
  endfunction

  // -------------------------------------------------------------------------
  // Input coordinate arrays
  // -------------------------------------------------------------------------
  logic [15:0] in_h [4];
  logic [15:0] in_v [4];

  assign in_h[0] = i_POINT_H_0;
  assign in_h[1] = i_POINT_H_1;
  assign in_h[2] = i_POINT_H_2;
  assign in_h[3] = i_POINT_H_3;
  assign in_v[0] = i_POINT_V_0;
  assign in_v[1] = i_POINT_V_1;
  assign in_v[2] = i_POINT_V_2;
  assign in_v[3] = i_POINT_V_3;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic        hs_q;
  logic        vs_q;
  logic        flag_q;
  logic        done_q;
  logic [15:0] frame_cnt;

  logic [3:0]  stg_en;
  logic [15:0] stg_h [4];
  logic [15:0] stg_v [4];
  logic [3:0]  shd_en;
  logic [15:0] shd_h [4];
  logic [15:0] shd_v [4];

  // Load handshake: i_LOAD is a one-cycle strobe with no back-pressure. The
  // block always accepts it; a later strobe before the frame boundary simply
  // replaces the staged set. o_LOAD_PENDING mirrors LOAD_PENDING, and
  // o_LOAD_DONE pulses on the first pixel that uses the applied set.
  typedef enum logic {
    LOAD_IDLE    = 1'b0,
    LOAD_PENDING = 1'b1
  } load_state_t;

  load_state_t load_state;
  load_state_t load_state_next;

  // -------------------------------------------------------------------------
  // Next pixel position
  // -------------------------------------------------------------------------
  logic        h_wrap;
  logic        boundary;
  logic [15:0] h_next;
  logic [15:0] v_next;

  assign h_wrap   = (h_cnt == H_LAST);
  assign boundary = h_wrap && (v_cnt == V_LAST);

  always_comb begin
    h_next = h_cnt + 16'd1;
    v_next = v_cnt;
    if (h_wrap) begin
      h_next = '0;
      v_next = (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Load FSM next state. apply_set marks the boundary cycle in which the
  // shadow copy is replaced; a strobe landing exactly on the boundary is
  // applied directly from the inputs.
  // -------------------------------------------------------------------------
  logic apply_set;

  always_comb begin
    load_state_next = load_state;
    apply_set       = 1'b0;
    if (boundary && ((load_state == LOAD_PENDING) || i_LOAD)) begin
      load_state_next = LOAD_IDLE;
      apply_set       = 1'b1;
    end else if (i_LOAD) begin
      load_state_next = LOAD_PENDING;
    end
  end

  // -------------------------------------------------------------------------
  // Effective blob set for the pixel being computed. In the boundary cycle the
  // next pixel is (0,0) of the new frame, so it must already see the set that
  // is being applied.
  // -------------------------------------------------------------------------
  logic [3:0]  eff_en;
  logic [15:0] eff_h [4];
  logic [15:0] eff_v [4];

  always_comb begin
    eff_en = shd_en;
    for (int k = 0; k < 4; k++) begin
      eff_h[k] = shd_h[k];
      eff_v[k] = shd_v[k];
    end
    if (apply_set) begin
      if (i_LOAD) begin
        eff_en = i_POINT_EN;
        for (int k = 0; k < 4; k++) begin
          eff_h[k] = in_h[k];
          eff_v[k] = in_v[k];
        end
      end else begin
        eff_en = stg_en;
        for (int k = 0; k < 4; k++) begin
          eff_h[k] = stg_h[k];
          eff_v[k] = stg_v[k];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Syncs and flag for the next pixel
  // -------------------------------------------------------------------------
  logic hs_next;
  logic vs_next;
  logic hit_any;
  logic flag_next;

  always_comb begin
    hs_next = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
    vs_next = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
    hit_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (eff_en[k] && blob_hit(h_next, v_next, eff_h[k], eff_v[k])) begin
        hit_any = 1'b1;
      end
    end
    // Clipping to the visible area is done here, so blobs hanging over an
    // edge simply lose their outside part.
    flag_next = i_ENABLE && (h_next < H_ACT_W) && (v_next < V_ACT_W) && hit_any;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      load_state <= LOAD_IDLE;
    end else begin
      load_state <= load_state_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      flag_q    <= 1'b0;
      done_q    <= 1'b0;
      frame_cnt <= '0;
      stg_en    <= '0;
      shd_en    <= '0;
      for (int k = 0; k < 4; k++) begin
        stg_h[k] <= '0;
        stg_v[k] <= '0;
        shd_h[k] <= '0;
        shd_v[k] <= '0;
      end
    end else begin
      h_cnt  <= h_next;
      v_cnt  <= v_next;
      hs_q   <= hs_next;
      vs_q   <= vs_next;
      flag_q <= flag_next;
      done_q <= apply_set;
      if (boundary) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (i_LOAD) begin
        stg_en <= i_POINT_EN;
        for (int k = 0; k < 4; k++) begin
          stg_h[k] <= in_h[k];
          stg_v[k] <= in_v[k];
        end
      end
      if (apply_set) begin
        shd_en <= eff_en;
        for (int k = 0; k < 4; k++) begin
          shd_h[k] <= eff_h[k];
          shd_v[k] <= eff_v[k];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign H_CNT          = h_cnt;
  assign V_CNT          = v_cnt;
  assign VGA_HS         = hs_q;
  assign VGA_VS         = vs_q;
  assign BINARY_FLAG    = flag_q;
  assign o_LOAD_PENDING = (load_state == LOAD_PENDING);
  assign o_LOAD_DONE    = done_q;
  assign o_FRAME_CNT    = frame_cnt;

endmodule
